// File: rtl/mux_rr_arbiter_3bit.sv
// Round-robin arbiter and select sequencer for the 4-to-1, 3-bit selector.
// Four requesters (x, y, z, w) share the selector output. Each ownership is
// capped at HOLD_MAX cycles and one dead cycle separates consecutive owners.
// The select lines only move when a new grant is issued, so the selected
// input stays stable through the dead cycle and while idle.
module mux_rr_arbiter_3bit #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic [1:0] owner
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Counter value on which the current owner's grant expires.
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

  state_t     state;
  logic [1:0] last;
  logic [3:0] cnt;
  logic [1:0] sel;

  logic       win_valid;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       release_now;

  assign s1 = sel[1];
  assign s0 = sel[0];

  // Rotating priority search starting one past the most recent owner; the
  // loop runs from lowest to highest priority so the best candidate wins last.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = last;
    cand      = last;
    for (int i = 4; i >= 1; i--) begin
      cand = last + 2'(i);
      if (req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Owner gives up the output when it stops requesting or its hold expires.
  always_comb begin
    release_now = (req[owner] == 1'b0) || (cnt == HOLD_LAST);
  end

  // Arbiter FSM with every output held in a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'b00;
      busy  <= 1'b0;
      owner <= 2'b00;
      last  <= 2'b11;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE, RELEASE: begin
          if (win_valid) begin
            state <= GRANT;
            owner <= win_idx;
            sel   <= win_idx;
            gnt   <= 4'b0001 << win_idx;
            cnt   <= 4'd0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            gnt   <= 4'b0000;
            busy  <= 1'b0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state <= RELEASE;
            gnt   <= 4'b0000;
            last  <= owner;
            busy  <= 1'b1;
          end else begin
            cnt   <= cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'b0000;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
